// File: rtl/rv_defs_pkg.sv
// rv_defs: shared definitions for the multi-cycle RV32I control unit.
//   - RV32I major opcode constants
//   - ALU operation codes ({funct7[5], funct3} encoding)
//   - datapath mux select codes (ALU B operand, writeback source, PC source)
//   - FSM state enumeration
package rv_defs;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  // ALU B operand select
  localparam logic [1:0] ALUB_RS2 = 2'b00;
  localparam logic [1:0] ALUB_IMM = 2'b01;

  // Register writeback source select
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_IMM = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;
  localparam logic [1:0] WB_PC4 = 2'b11;

  // PC source select
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_REL   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  // Memory size code shown whenever no load/store is in progress (word)
  localparam logic [1:0] MEM_SIZE_IDLE = 2'b10;

  // Eighteen states including the one-cycle ILL decision state, so the
  // encoding needs five bits.
  typedef enum logic [4:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_LUI_WB,
    S_AUIPC, S_ADDR, S_LOAD_RD, S_LOAD_WB, S_STORE, S_JAL, S_JALR,
    S_BR_CMP, S_BR_TAKE, S_ILL, S_TRAP
  } state_e;

  // Legal load widths: LB, LH, LW, LBU, LHU
  function automatic logic load_f3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  // Legal store widths: SB, SH, SW
  function automatic logic store_f3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
  endfunction

endpackage

// File: rtl/rv_branch_cond.sv
// rv_branch_cond: combinational branch-condition evaluator.
//   funct3 - branch type (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   zf     - ALU zero flag from rs1-rs2
//   lt     - signed rs1 < rs2
//   ltu    - unsigned rs1 < rs2
//   taken  - branch condition satisfied (0 for the reserved funct3 codes)
module rv_branch_cond (
  input  logic [2:0] funct3,
  input  logic       zf,
  input  logic       lt,
  input  logic       ltu,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zf;
      3'b001:  taken = ~zf;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv_mc_ctrl_gen2.sv
// rv_mc_ctrl_gen2: multi-cycle RV32I control FSM (Moore outputs).
// Inputs : clk, rst_n (async, active-low), opcode/funct3/funct7_5 from IR,
//          zf/lt/ltu ALU flags, mem_ready memory handshake.
// Outputs: alu_op, alu_a_s, alu_b_s, wb_s, reg_write, ir_write, pc_write,
//          pc0_write, pc_s, mem_read, mem_write, mem_size, mem_uns, illegal.
// Parameters: ALU_OP_W (alu_op width), MEM_HANDSHAKE (stall on mem_ready),
//             TRAP_ON_ILL (illegal -> sticky TRAP, else skip as NOP).
module rv_mc_ctrl_gen2
  import rv_defs::*;
#(
  parameter int ALU_OP_W      = 4,
  parameter int MEM_HANDSHAKE = 1,
  parameter int TRAP_ON_ILL   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                funct7_5,
  input  logic                zf,
  input  logic                lt,
  input  logic                ltu,
  input  logic                mem_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_a_s,
  output logic [1:0]          alu_b_s,
  output logic [1:0]          wb_s,
  output logic                reg_write,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc0_write,
  output logic [1:0]          pc_s,
  output logic                mem_read,
  output logic                mem_write,
  output logic [1:0]          mem_size,
  output logic                mem_uns,
  output logic                illegal
);

  state_e     state_q, state_d;
  logic       taken_q, taken_d;
  logic       rdy;
  logic       br_taken;
  logic [3:0] alu_op_c;

  // With the handshake disabled every memory access completes in one cycle.
  assign rdy    = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign alu_op = ALU_OP_W'(alu_op_c);

  rv_branch_cond u_branch_cond (
    .funct3 (funct3),
    .zf     (zf),
    .lt     (lt),
    .ltu    (ltu),
    .taken  (br_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      taken_q <= taken_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    taken_d   = taken_q;
    alu_op_c  = ALU_ADD;
    alu_a_s   = 1'b0;
    alu_b_s   = ALUB_RS2;
    wb_s      = WB_ALU;
    reg_write = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc0_write = 1'b0;
    pc_s      = PC_PLUS4;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_size  = MEM_SIZE_IDLE;
    mem_uns   = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_read  = 1'b1;
        pc_s      = PC_PLUS4;
        ir_write  = rdy;
        pc_write  = rdy;
        pc0_write = rdy;
        if (rdy) state_d = S_DECODE;
      end

      S_DECODE: begin
        case (opcode)
          OP_R:      state_d = S_EXEC_R;
          OP_IMM:    state_d = S_EXEC_I;
          OP_LUI:    state_d = S_LUI_WB;
          OP_AUIPC:  state_d = S_AUIPC;
          OP_LOAD:   state_d = load_f3_ok(funct3)  ? S_ADDR : S_ILL;
          OP_STORE:  state_d = store_f3_ok(funct3) ? S_ADDR : S_ILL;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = (funct3 == 3'b000) ? S_JALR : S_ILL;
          OP_BRANCH: state_d = (funct3[2:1] == 2'b01) ? S_ILL : S_BR_CMP;
          default:   state_d = S_ILL;
        endcase
      end

      S_ILL: state_d = (TRAP_ON_ILL != 0) ? S_TRAP : S_FETCH;

      // Sticky: only rst_n leaves TRAP.
      S_TRAP: illegal = 1'b1;

      S_EXEC_R: begin
        alu_b_s  = ALUB_RS2;
        alu_op_c = {funct7_5, funct3};
        state_d  = S_ALU_WB;
      end

      // IR[30] only selects SRAI over SRLI; for other I-types it is immediate data.
      S_EXEC_I: begin
        alu_b_s  = ALUB_IMM;
        alu_op_c = {funct7_5 & (funct3 == 3'b101), funct3};
        state_d  = S_ALU_WB;
      end

      S_ALU_WB: begin
        reg_write = 1'b1;
        wb_s      = WB_ALU;
        state_d   = S_FETCH;
      end

      S_LUI_WB: begin
        reg_write = 1'b1;
        wb_s      = WB_IMM;
        state_d   = S_FETCH;
      end

      S_AUIPC: begin
        alu_a_s   = 1'b1;
        alu_b_s   = ALUB_IMM;
        alu_op_c  = ALU_ADD;
        reg_write = 1'b1;
        wb_s      = WB_ALU;
        state_d   = S_FETCH;
      end

      S_ADDR: begin
        alu_b_s  = ALUB_IMM;
        alu_op_c = ALU_ADD;
        state_d  = (opcode == OP_LOAD) ? S_LOAD_RD : S_STORE;
      end

      S_LOAD_RD: begin
        mem_read = 1'b1;
        mem_size = funct3[1:0];
        mem_uns  = funct3[2];
        if (rdy) state_d = S_LOAD_WB;
      end

      S_LOAD_WB: begin
        reg_write = 1'b1;
        wb_s      = WB_MEM;
        mem_size  = funct3[1:0];
        mem_uns   = funct3[2];
        state_d   = S_FETCH;
      end

      // Strobe only on the completing cycle so the write lands exactly once.
      S_STORE: begin
        mem_write = rdy;
        mem_size  = funct3[1:0];
        if (rdy) state_d = S_FETCH;
      end

      S_JAL: begin
        pc_s      = PC_REL;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        wb_s      = WB_PC4;
        state_d   = S_FETCH;
      end

      // rd gets the old PC+4 in the same cycle the ALU computes rs1+imm,
      // so rd == rs1 still jumps to the pre-write register value.
      S_JALR: begin
        alu_b_s   = ALUB_IMM;
        alu_op_c  = ALU_ADD;
        pc_s      = PC_ALU;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        wb_s      = WB_PC4;
        state_d   = S_FETCH;
      end

      S_BR_CMP: begin
        alu_b_s  = ALUB_RS2;
        alu_op_c = ALU_SUB;
        taken_d  = br_taken;
        state_d  = S_BR_TAKE;
      end

      S_BR_TAKE: begin
        pc_s     = PC_REL;
        pc_write = taken_q;
        state_d  = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rv_mc_ctrl_gen2.sv
module tb_rv_mc_ctrl_gen2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5, zf, lt, ltu, mem_ready;
  logic [3:0] alu_op;
  logic       alu_a_s;
  logic [1:0] alu_b_s, wb_s, pc_s, mem_size;
  logic       reg_write, ir_write, pc_write, pc0_write;
  logic       mem_read, mem_write, mem_uns, illegal;

  rv_mc_ctrl_gen2 #(.ALU_OP_W(4), .MEM_HANDSHAKE(1), .TRAP_ON_ILL(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zf(zf), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_a_s(alu_a_s), .alu_b_s(alu_b_s), .wb_s(wb_s),
    .reg_write(reg_write), .ir_write(ir_write), .pc_write(pc_write), .pc0_write(pc0_write),
    .pc_s(pc_s), .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_uns(mem_uns), .illegal(illegal)
  );

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_a_s;
    logic [1:0] alu_b_s;
    logic [1:0] wb_s;
    logic       reg_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc0_write;
    logic [1:0] pc_s;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       mem_uns;
    logic       illegal;
  } outv_t;

  typedef struct {
    outv_t ev;
    string tag;
  } exp_t;

  typedef enum {K_R, K_I, K_LUI, K_AUIPC, K_LOAD, K_STORE, K_JAL, K_JALR, K_BR, K_ILL} kind_t;

  exp_t  exp_q[$];
  exp_t  mon_e;
  outv_t act;
  string tag;
  int    n_checks = 0;
  int    n_pass   = 0;

  assign act = {alu_op, alu_a_s, alu_b_s, wb_s, reg_write, ir_write, pc_write, pc0_write,
                pc_s, mem_read, mem_write, mem_size, mem_uns, illegal};

  // Monitor: one expected output vector per clock cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if (act === mon_e.ev) n_pass++;
      else $display("FAIL %s: got %h expected %h", mon_e.tag, act, mon_e.ev);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic outv_t quiet();
    outv_t v = '0;
    v.mem_size = 2'b10;
    return v;
  endfunction

  // Instruction class as the ISA defines it.
  function automatic kind_t classify(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      7'b0000011: return (f3 == 3 || f3 == 6 || f3 == 7) ? K_ILL : K_LOAD;
      7'b0100011: return (f3 <= 2) ? K_STORE : K_ILL;
      7'b1101111: return K_JAL;
      7'b1100111: return (f3 == 0) ? K_JALR : K_ILL;
      7'b1100011: return (f3 == 2 || f3 == 3) ? K_ILL : K_BR;
      default:    return K_ILL;
    endcase
  endfunction

  // Branch outcome computed from the operand values themselves.
  function automatic bit br_outcome(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic cyc(input outv_t v, input logic rdy);
    exp_t e;
    mem_ready = rdy;
    e.ev  = v;
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tag = "reset";
    for (int i = 0; i < 2; i++) cyc(quiet(), rnd_bit());
    rst_n = 1'b1;
    tag = "idle_after_reset";
    cyc(quiet(), rnd_bit());
  endtask

  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic [31:0] a, input logic [31:0] b,
                           input int fw, input int mw, input bit abort);
    outv_t e;
    kind_t k;
    opcode = op; funct3 = f3; funct7_5 = f7;
    zf = (a == b); lt = ($signed(a) < $signed(b)); ltu = (a < b);
    k = classify(op, f3);
    tag = {name, ".fetch"};
    for (int i = 0; i <= fw; i++) begin
      e = quiet(); e.mem_read = 1'b1;
      e.ir_write = (i == fw); e.pc_write = (i == fw); e.pc0_write = (i == fw);
      cyc(e, logic'(i == fw));
    end
    tag = {name, ".decode"};
    cyc(quiet(), rnd_bit());
    tag = {name, ".exec"};
    case (k)
      K_R, K_I: begin
        e = quiet();
        e.alu_b_s = (k == K_I) ? 2'b01 : 2'b00;
        e.alu_op  = (k == K_I) ? {f7 & (f3 == 3'd5), f3} : {f7, f3};
        cyc(e, rnd_bit());
        e = quiet(); e.reg_write = 1'b1; e.wb_s = 2'b00;
        tag = {name, ".wb"};
        cyc(e, rnd_bit());
      end
      K_LUI: begin
        e = quiet(); e.reg_write = 1'b1; e.wb_s = 2'b01;
        cyc(e, rnd_bit());
      end
      K_AUIPC: begin
        e = quiet(); e.alu_a_s = 1'b1; e.alu_b_s = 2'b01; e.reg_write = 1'b1;
        cyc(e, rnd_bit());
      end
      K_LOAD, K_STORE: begin
        e = quiet(); e.alu_b_s = 2'b01;
        cyc(e, rnd_bit());
        tag = {name, ".mem"};
        for (int i = 0; i <= mw; i++) begin
          e = quiet(); e.mem_size = f3[1:0];
          if (k == K_LOAD) begin
            e.mem_read = 1'b1; e.mem_uns = f3[2];
          end else begin
            e.mem_write = (i == mw);
          end
          cyc(e, logic'(i == mw));
          if (abort && i == 1) begin
            do_reset();
            return;
          end
        end
        if (k == K_LOAD) begin
          e = quiet(); e.reg_write = 1'b1; e.wb_s = 2'b10;
          e.mem_size = f3[1:0]; e.mem_uns = f3[2];
          tag = {name, ".wb"};
          cyc(e, rnd_bit());
        end
      end
      K_JAL: begin
        e = quiet(); e.pc_s = 2'b01; e.pc_write = 1'b1; e.reg_write = 1'b1; e.wb_s = 2'b11;
        cyc(e, rnd_bit());
      end
      K_JALR: begin
        e = quiet(); e.alu_b_s = 2'b01; e.pc_s = 2'b10; e.pc_write = 1'b1;
        e.reg_write = 1'b1; e.wb_s = 2'b11;
        cyc(e, rnd_bit());
      end
      K_BR: begin
        e = quiet(); e.alu_op = 4'b1000;
        cyc(e, rnd_bit());
        e = quiet(); e.pc_s = 2'b01; e.pc_write = br_outcome(f3, a, b);
        tag = {name, ".take"};
        cyc(e, rnd_bit());
      end
      default: begin
        tag = {name, ".ill"};
        cyc(quiet(), rnd_bit());
        tag = {name, ".trap"};
        for (int i = 0; i < 3; i++) begin
          e = quiet(); e.illegal = 1'b1;
          cyc(e, rnd_bit());
        end
        do_reset();
      end
    endcase
  endtask

  task automatic run_random();
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [6:0]  ops[9];
    ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
            7'b0100011, 7'b1101111, 7'b1100111, 7'b1100011};
    f3 = 3'($urandom);
    if ($urandom_range(0, 19) == 0) op = 7'($urandom);
    else op = ops[$urandom_range(0, 8)];
    a = $urandom;
    b = ($urandom_range(0, 2) == 0) ? a : $urandom;
    run_instr("rand", op, f3, rnd_bit(), a, b, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0;
    zf = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    run_instr("addi",  7'b0010011, 3'b000, 1'b0, 0, 0, 0, 0, 1'b0);
    run_instr("srai",  7'b0010011, 3'b101, 1'b1, 0, 0, 0, 0, 1'b0);
    run_instr("slli",  7'b0010011, 3'b001, 1'b0, 0, 0, 0, 0, 1'b0);
    run_instr("sub",   7'b0110011, 3'b000, 1'b1, 0, 0, 0, 0, 1'b0);
    run_instr("beq",   7'b1100011, 3'b000, 1'b0, 32'h55, 32'h55, 0, 0, 1'b0);
    run_instr("bltu",  7'b1100011, 3'b110, 1'b0, 32'h10, 32'h5, 0, 0, 1'b0);
    run_instr("bge",   7'b1100011, 3'b101, 1'b0, 32'h7, 32'h3, 0, 0, 1'b0);
    run_instr("lh",    7'b0000011, 3'b001, 1'b0, 0, 0, 0, 3, 1'b0);
    run_instr("sb",    7'b0100011, 3'b000, 1'b0, 0, 0, 1, 2, 1'b0);
    run_instr("lbu",   7'b0000011, 3'b100, 1'b0, 0, 0, 0, 0, 1'b0);
    run_instr("lui",   7'b0110111, 3'b000, 1'b0, 0, 0, 0, 0, 1'b0);
    run_instr("auipc", 7'b0010111, 3'b000, 1'b0, 0, 0, 0, 0, 1'b0);
    run_instr("jal",   7'b1101111, 3'b000, 1'b0, 0, 0, 0, 0, 1'b0);
    run_instr("jalr",  7'b1100111, 3'b000, 1'b0, 0, 0, 0, 0, 1'b0);
    run_instr("ill7f", 7'b1111111, 3'b000, 1'b0, 0, 0, 0, 0, 1'b0);
    run_instr("addi2", 7'b0010011, 3'b000, 1'b0, 0, 0, 0, 0, 1'b0);
    run_instr("lw_abort", 7'b0000011, 3'b010, 1'b0, 0, 0, 0, 3, 1'b1);
    run_instr("bne_ill", 7'b1100011, 3'b010, 1'b0, 0, 0, 0, 0, 1'b0);
    for (int n = 0; n < 200; n++) run_random();
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
